// File: rtl/link_arbiter_rr.sv
// Round-robin arbiter: N requesters share one registered valid/ready output link.
// Optional core priority for index N-1, plus a saturating back-pressure counter.
module link_arbiter_rr #(
  parameter int WIDTH     = 11,
  parameter int ID_W      = 3,
  parameter int N         = 5,
  parameter int CNT_W     = 8,
  parameter int CORE_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N*ID_W-1:0]    in_id,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [ID_W-1:0]      out_id,
  output logic [2:0]           out_src,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [PW-1:0]     ptr_r;
  logic [PW-1:0]     ptr_nxt_s;
  logic [PW-1:0]     win_s;
  logic              any_s;
  logic              load_s;
  logic              accept_s;
  logic [N-1:0]      grant_s;
  logic [WIDTH-1:0]  data_r;
  logic [ID_W-1:0]   id_r;
  logic [2:0]        src_r;
  logic [CNT_W-1:0]  stall_r;

  // Winner search: first valid requester at or after ptr, with optional core override.
  always_comb begin
    int idx_v;
    idx_v = 0;
    win_s = '0;
    any_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_v = (int'(ptr_r) + k >= N) ? int'(ptr_r) + k - N : int'(ptr_r) + k;
      if (!any_s && in_valid[PW'(idx_v)]) begin
        any_s = 1'b1;
        win_s = PW'(idx_v);
      end else begin
        any_s = any_s;
      end
    end
    if ((CORE_PRIO != 0) && in_valid[N-1]) begin
      win_s = PW'(N - 1);
    end else begin
      win_s = win_s;
    end
  end

  // Next state, pointer advance and one-hot grant.
  always_comb begin
    load_s      = (state_r == EMPTY) || out_ready;
    accept_s    = load_s && any_s;
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    grant_s     = '0;
    if (accept_s) begin
      state_nxt_s    = FULL;
      grant_s[win_s] = 1'b1;
      // Priority grants to the core leave the rotation where it was.
      if ((CORE_PRIO != 0) && (win_s == PW'(N - 1))) begin
        ptr_nxt_s = ptr_r;
      end else if (win_s == PW'(N - 1)) begin
        ptr_nxt_s = '0;
      end else begin
        ptr_nxt_s = win_s + PW'(1);
      end
    end else if (load_s) begin
      state_nxt_s = EMPTY;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Grants are suppressed while reset is asserted.
  always_comb begin
    if (rst_n) begin
      in_ready = grant_s;
    end else begin
      in_ready = '0;
    end
  end

  // FSM state and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      ptr_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
    end
  end

  // Output flit register; holds its contents when draining to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
      id_r   <= '0;
      src_r  <= 3'd0;
    end else if (accept_s) begin
      data_r <= in_data[int'(win_s)*WIDTH +: WIDTH];
      id_r   <= in_id[int'(win_s)*ID_W +: ID_W];
      src_r  <= 3'(win_s);
    end else begin
      data_r <= data_r;
      id_r   <= id_r;
      src_r  <= src_r;
    end
  end

  // Saturating count of stalled output cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= '0;
    end else if ((state_r == FULL) && !out_ready && (stall_r != {CNT_W{1'b1}})) begin
      stall_r <= stall_r + CNT_W'(1);
    end else begin
      stall_r <= stall_r;
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_data  = data_r;
  assign out_id    = id_r;
  assign out_src   = src_r;
  assign stall_cnt = stall_r;

endmodule

// File: tb/tb_link_arbiter_rr.sv
// Scoreboard bench for link_arbiter_rr: one pure round-robin and one core-priority
// instance, each checked against a rule-level reference model.
module tb_link_arbiter_rr;

  localparam int W  = 11;
  localparam int IW = 3;
  localparam int N  = 5;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_ready = 1'b0;

  logic [N-1:0]    in_valid   [2];
  logic [N*W-1:0]  in_data    [2];
  logic [N*IW-1:0] in_id      [2];
  logic [N-1:0]    in_ready_o [2];
  logic            out_valid_o[2];
  logic [W-1:0]    out_data_o [2];
  logic [IW-1:0]   out_id_o   [2];
  logic [2:0]      out_src_o  [2];
  logic [CW-1:0]   stall_o    [2];
  logic [N-1:0]    gnt        [2];

  int ptr_m   [2];
  int stall_m [2];
  int full_m  [2];
  int prio_m  [2] = '{0, 1};
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [W-1:0] hold_d [2];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  link_arbiter_rr #(.WIDTH(W), .ID_W(IW), .N(N), .CNT_W(CW), .CORE_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_data(in_data[0]), .in_id(in_id[0]),
    .in_ready(in_ready_o[0]), .out_valid(out_valid_o[0]), .out_data(out_data_o[0]),
    .out_id(out_id_o[0]), .out_src(out_src_o[0]), .out_ready(out_ready), .stall_cnt(stall_o[0]));

  link_arbiter_rr #(.WIDTH(W), .ID_W(IW), .N(N), .CNT_W(CW), .CORE_PRIO(1)) u_cp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_data(in_data[1]), .in_id(in_id[1]),
    .in_ready(in_ready_o[1]), .out_valid(out_valid_o[1]), .out_data(out_data_o[1]),
    .out_id(out_id_o[1]), .out_src(out_src_o[1]), .out_ready(out_ready), .stall_cnt(stall_o[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Winner chosen by the arbitration rules from the model pointer.
  function automatic int win_m(input int j);
    if (prio_m[j] != 0 && in_valid[j][N-1]) return N - 1;
    for (int k = 0; k < N; k++)
      if (in_valid[j][(ptr_m[j] + k) % N]) return (ptr_m[j] + k) % N;
    return -1;
  endfunction

  // Called at the falling edge: check combinational/registered state, then advance the model.
  task automatic model_eval();
    for (int j = 0; j < 2; j++) begin
      int w;
      bit load;
      logic [N-1:0] exp_rdy;
      w = win_m(j);
      load = (full_m[j] == 0) || out_ready;
      exp_rdy = '0;
      if (load && w >= 0) exp_rdy[w] = 1'b1;
      chk($sformatf("in_ready%0d", j), 32'(in_ready_o[j]), 32'(exp_rdy));
      chk($sformatf("out_valid%0d", j), 32'(out_valid_o[j]), 32'(full_m[j]));
      chk($sformatf("stall_cnt%0d", j), 32'(stall_o[j]), 32'(stall_m[j]));
      if (full_m[j] != 0 && !out_ready && stall_m[j] < 255) stall_m[j]++;
      if (load) begin
        if (w >= 0) begin
          logic [16:0] e;
          e = {in_data[j][w*W +: W], in_id[j][w*IW +: IW], 3'(w)};
          if (j == 0) q0.push_back(e); else q1.push_back(e);
          if (!(prio_m[j] != 0 && w == N - 1)) ptr_m[j] = (w + 1) % N;
          full_m[j] = 1;
        end else begin
          full_m[j] = 0;
        end
      end
      gnt[j] = in_ready_o[j];
    end
  endtask

  // One cycle: requesters retire granted flits and may raise new ones (only in mask).
  task automatic step(input logic [N-1:0] mask, input int p_req, input int p_rdy);
    @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[j][i] && gnt[j][i]) in_valid[j][i] = 1'b0;
        if (!in_valid[j][i] && mask[i] && ($urandom_range(99) < p_req)) begin
          in_valid[j][i] = 1'b1;
          in_data[j][i*W +: W] = W'($urandom);
          in_id[j][i*IW +: IW] = IW'($urandom);
        end
      end
    end
    out_ready = ($urandom_range(99) < p_rdy);
    @(negedge clk);
    model_eval();
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int j = 0; j < 2; j++) begin
      ptr_m[j] = 0;
      full_m[j] = 0;
      stall_m[j] = 0;
      in_valid[j] = '0;
      gnt[j] = '0;
    end
  endtask

  // Monitor: every output transfer is matched against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    logic [16:0] e;
    if (rst_n) begin
      for (int j = 0; j < 2; j++) begin
        if (out_valid_o[j] && out_ready) begin
          if ((j == 0 && q0.size() == 0) || (j == 1 && q1.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_unexpected%0d: got out_valid=1 required no pending flit", j);
          end else begin
            if (j == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk($sformatf("out_data%0d", j), 32'(out_data_o[j]), 32'(e[16:6]));
            chk($sformatf("out_id%0d", j), 32'(out_id_o[j]), 32'(e[5:3]));
            chk($sformatf("out_src%0d", j), 32'(out_src_o[j]), 32'(e[2:0]));
          end
        end
      end
    end
  end

  initial begin
    for (int j = 0; j < 2; j++) begin
      in_valid[j] = '0;
      in_data[j] = '0;
      in_id[j] = '0;
    end
    model_reset();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("rst_out_valid%0d", j), 32'(out_valid_o[j]), 32'd0);
      chk($sformatf("rst_out_data%0d", j), 32'(out_data_o[j]), 32'd0);
      chk($sformatf("rst_out_id%0d", j), 32'(out_id_o[j]), 32'd0);
      chk($sformatf("rst_out_src%0d", j), 32'(out_src_o[j]), 32'd0);
      chk($sformatf("rst_stall%0d", j), 32'(stall_o[j]), 32'd0);
      chk($sformatf("rst_in_ready%0d", j), 32'(in_ready_o[j]), 32'd0);
    end
    rst_n = 1'b1;

    // Single requester with a fixed flit.
    for (int j = 0; j < 2; j++) begin
      in_valid[j] = 5'b00100;
      in_data[j][2*W +: W] = 11'h2A5;
      in_id[j][2*IW +: IW] = 3'd2;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_in_ready", 32'(in_ready_o[0]), 32'h04);
    model_eval();
    step(5'b00000, 0, 100);
    chk("t2_out_data", 32'(out_data_o[0]), 32'h2A5);
    chk("t2_out_src", 32'(out_src_o[1]), 32'd2);

    // Fairness under continuous full load.
    repeat (12) step(5'b11111, 100, 100);
    repeat (7) step(5'b00000, 0, 100);

    // Wrap: grant 3 moves ptr to 4, then requesters 0 and 1.
    step(5'b01000, 100, 100);
    repeat (4) step(5'b00011, 100, 100);
    repeat (7) step(5'b00000, 0, 100);

    // Core priority from ptr=1, then core drops out.
    step(5'b00001, 100, 100);
    repeat (6) step(5'b11111, 100, 100);
    repeat (8) step(5'b01111, 100, 100);
    repeat (7) step(5'b00000, 0, 100);

    // Long back-pressure saturates the stall counter and freezes the output.
    repeat (2) step(5'b11111, 100, 0);
    for (int j = 0; j < 2; j++) hold_d[j] = out_data_o[j];
    repeat (300) step(5'b11111, 100, 0);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("t4_hold%0d", j), 32'(out_data_o[j]), 32'(hold_d[j]));
      chk($sformatf("t4_stall%0d", j), 32'(stall_o[j]), 32'd255);
    end

    // Random traffic.
    repeat (400) step(N'($urandom), 50, 60);

    // Reset asserted mid-cycle while a flit is held.
    repeat (3) step(5'b11111, 100, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("t1_out_valid%0d", j), 32'(out_valid_o[j]), 32'd0);
      chk($sformatf("t1_stall%0d", j), 32'(stall_o[j]), 32'd0);
      chk($sformatf("t1_in_ready%0d", j), 32'(in_ready_o[j]), 32'd0);
    end
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(5'b01010, 100, 100);
    repeat (200) step(N'($urandom), 60, 50);

    // Drain everything and confirm nothing is left pending.
    repeat (8) step(5'b00000, 0, 100);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
